regfile_scoreboard: RTL and testbench

//   Parametrised 1W/2R register file for the dedicated-datapath CPU, sized by DATA_W/DEPTH.
//   Per-register busy scoreboard: an issuing stage reserves a destination, and the later write-back clears it.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_sb_tracker.sv | 73 +++++++
 rtl/regfile_scoreboard.sv | 94 +++++++++
 tb/tb_regfile_scoreboard.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg : shared defaults, types and sizing helper for regfile_scoreboard
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;
  localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);

  typedef logic [DATA_W_DEF-1:0] data_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

  // Counter must hold every value from 0 up to DEPTH inclusive.
  function automatic int busy_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/regfile_sb_tracker.sv
// ---------------------------------------------------------------------------
// regfile_sb_tracker : per-register busy bits, reserve grant and busy count
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_sb_tracker
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ZERO_REG = 1,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int CNT_W    = busy_cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic              i_rsv_en,
  input  logic [ADDR_W-1:0] i_rsv_addr,
  output logic [DEPTH-1:0]  o_busy,
  output logic              o_rsv_grant,
  output logic [CNT_W-1:0]  o_busy_cnt
);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_rsv_zero;
  logic             w_wr_live;
  logic             w_grant;
  logic             w_dec;

  assign w_rsv_zero = (ZERO_REG != 0) && (i_rsv_addr == '0);
  assign w_wr_live  = i_wr_en && !((ZERO_REG != 0) && (i_wr_addr == '0));
  assign w_grant    = i_rsv_en && !r_busy[i_rsv_addr] && !w_rsv_zero;
  // A same-address reserve can only be granted when the bit was clear,
  // so a decrement never coincides with re-setting the same bit.
  assign w_dec      = w_wr_live && r_busy[i_wr_addr];

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_live) w_busy_nxt[i_wr_addr] = 1'b0;
    if (w_grant)   w_busy_nxt[i_rsv_addr] = 1'b1;
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_grant, w_dec})
      2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
      2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign o_busy      = r_busy;
  assign o_rsv_grant = w_grant;
  assign o_busy_cnt  = r_cnt;

endmodule : regfile_sb_tracker

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard : 1W/2R register file with busy scoreboard
// Optional macro REGFILE_BYPASS_EN : forward write-back data to read ports.
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic                         iClk,
  input  logic                         iRst_n,
  input  logic                         iWrEn,
  input  logic [ADDR_W-1:0]            iWrAddr,
  input  logic [DATA_W-1:0]            iWrData,
  input  logic [ADDR_W-1:0]            iRdAddr0,
  input  logic [ADDR_W-1:0]            iRdAddr1,
  output logic [DATA_W-1:0]            oRdData0,
  output logic [DATA_W-1:0]            oRdData1,
  output logic                         oBusy0,
  output logic                         oBusy1,
  input  logic                         iRsvEn,
  input  logic [ADDR_W-1:0]            iRsvAddr,
  output logic                         oRsvGrant,
  output logic [busy_cnt_w(DEPTH)-1:0] oBusyCnt
);

  localparam int CNT_W = busy_cnt_w(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  w_busy;
  logic              w_wr_live;
  logic              w_zero0;
  logic              w_zero1;
  logic [DATA_W-1:0] w_rd0;
  logic [DATA_W-1:0] w_rd1;
  logic              w_bsy0;
  logic              w_bsy1;

  regfile_sb_tracker #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG),
    .ADDR_W   (ADDR_W),
    .CNT_W    (CNT_W)
  ) u_tracker (
    .clk         (iClk),
    .rst_n       (iRst_n),
    .i_wr_en     (iWrEn),
    .i_wr_addr   (iWrAddr),
    .i_rsv_en    (iRsvEn),
    .i_rsv_addr  (iRsvAddr),
    .o_busy      (w_busy),
    .o_rsv_grant (oRsvGrant),
    .o_busy_cnt  (oBusyCnt)
  );

  assign w_wr_live = iWrEn && !((ZERO_REG != 0) && (iWrAddr == '0));

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_live) begin
      r_mem[iWrAddr] <= iWrData;
    end
  end

  assign w_zero0 = (ZERO_REG != 0) && (iRdAddr0 == '0);
  assign w_zero1 = (ZERO_REG != 0) && (iRdAddr1 == '0);
  assign w_rd0   = w_zero0 ? '0   : r_mem[iRdAddr0];
  assign w_rd1   = w_zero1 ? '0   : r_mem[iRdAddr1];
  assign w_bsy0  = w_zero0 ? 1'b0 : w_busy[iRdAddr0];
  assign w_bsy1  = w_zero1 ? 1'b0 : w_busy[iRdAddr1];

`ifdef REGFILE_BYPASS_EN
  // w_wr_live already excludes the hardwired zero register.
  assign oRdData0 = (w_wr_live && (iWrAddr == iRdAddr0)) ? iWrData : w_rd0;
  assign oRdData1 = (w_wr_live && (iWrAddr == iRdAddr1)) ? iWrData : w_rd1;
  assign oBusy0   = (w_wr_live && (iWrAddr == iRdAddr0)) ? 1'b0    : w_bsy0;
  assign oBusy1   = (w_wr_live && (iWrAddr == iRdAddr1)) ? 1'b0    : w_bsy1;
`else
  assign oRdData0 = w_rd0;
  assign oRdData1 = w_rd1;
  assign oBusy0   = w_bsy0;
  assign oBusy1   = w_bsy1;
`endif

endmodule : regfile_scoreboard

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_regfile_scoreboard : directed self-checking bench for regfile_scoreboard
// Revision              : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_regfile_scoreboard;
  import regfile_pkg::*;

  logic       iClk = 1'b0;
  logic       iRst_n;
  logic       iWrEn;
  addr_t      iWrAddr;
  data_t      iWrData;
  addr_t      iRdAddr0;
  addr_t      iRdAddr1;
  data_t      oRdData0;
  data_t      oRdData1;
  logic       oBusy0;
  logic       oBusy1;
  logic       iRsvEn;
  addr_t      iRsvAddr;
  logic       oRsvGrant;
  logic [2:0] oBusyCnt;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_scoreboard dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iWrEn     (iWrEn),
    .iWrAddr   (iWrAddr),
    .iWrData   (iWrData),
    .iRdAddr0  (iRdAddr0),
    .iRdAddr1  (iRdAddr1),
    .oRdData0  (oRdData0),
    .oRdData1  (oRdData1),
    .oBusy0    (oBusy0),
    .oBusy1    (oBusy1),
    .iRsvEn    (iRsvEn),
    .iRsvAddr  (iRsvAddr),
    .oRsvGrant (oRsvGrant),
    .oBusyCnt  (oBusyCnt)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  initial begin
    iRst_n = 1'b0; iWrEn = 1'b0; iWrAddr = '0; iWrData = '0;
    iRdAddr0 = '0; iRdAddr1 = '0; iRsvEn = 1'b0; iRsvAddr = '0;
    #12;
    // 1. reset state on every address
    for (int a = 0; a < 4; a++) begin
      iRdAddr0 = addr_t'(a);
      iRdAddr1 = addr_t'(3 - a);
      #1;
      chk($sformatf("rst_d0_%0d", a), oRdData0, 0);
      chk($sformatf("rst_d1_%0d", a), oRdData1, 0);
      chk($sformatf("rst_b0_%0d", a), oBusy0, 0);
      chk($sformatf("rst_b1_%0d", a), oBusy1, 0);
    end
    chk("rst_cnt", oBusyCnt, 0);
    iRst_n = 1'b1;
    step();

    // 2. plain write, read back, and dropped write to r0
    iWrEn = 1'b1; iWrAddr = 2'd2; iWrData = 8'hA5;
    step();
    iWrEn = 1'b0; iRdAddr0 = 2'd2; iRdAddr1 = 2'd1;
    #1;
    chk("wr_r2", oRdData0, 8'hA5);
    chk("rd_r1", oRdData1, 8'h00);
    iWrEn = 1'b1; iWrAddr = 2'd0; iWrData = 8'hFF;
    step();
    iWrEn = 1'b0; iRdAddr0 = 2'd0;
    #1;
    chk("zero_r0", oRdData0, 8'h00);

    // 3. reserve, repeat reserve denied, r0 never reservable, write-back clears
    iRsvEn = 1'b1; iRsvAddr = 2'd3;
    #1;
    chk("rsv3_grant", oRsvGrant, 1);
    step();
    iRsvEn = 1'b0; iRdAddr0 = 2'd3;
    #1;
    chk("rsv3_busy", oBusy0, 1);
    chk("rsv3_cnt", oBusyCnt, 1);
    iRsvEn = 1'b1; iRsvAddr = 2'd3;
    #1;
    chk("rsv3_again", oRsvGrant, 0);
    iRsvAddr = 2'd0;
    #1;
    chk("rsv0_deny", oRsvGrant, 0);
    step();
    iRsvEn = 1'b0;
    #1;
    chk("rsv0_cnt", oBusyCnt, 1);
    iWrEn = 1'b1; iWrAddr = 2'd3; iWrData = 8'h3C;
    step();
    iWrEn = 1'b0;
    #1;
    chk("wb3_busy", oBusy0, 0);
    chk("wb3_cnt", oBusyCnt, 0);
    chk("wb3_data", oRdData0, 8'h3C);

    // 4. simultaneous write + reserve on the same address
    iRsvEn = 1'b1; iRsvAddr = 2'd1;
    step();
    iRsvEn = 1'b0;
    #1;
    chk("r1_cnt", oBusyCnt, 1);
    iWrEn = 1'b1; iWrAddr = 2'd1; iWrData = 8'h11;
    iRsvEn = 1'b1; iRsvAddr = 2'd1;
    #1;
    chk("r1_both_grant", oRsvGrant, 0);
    step();
    iWrEn = 1'b0; iRsvEn = 1'b0; iRdAddr0 = 2'd1;
    #1;
    chk("r1_both_busy", oBusy0, 0);
    chk("r1_both_data", oRdData0, 8'h11);
    chk("r1_both_cnt", oBusyCnt, 0);
    iWrEn = 1'b1; iWrAddr = 2'd2; iWrData = 8'h22;
    iRsvEn = 1'b1; iRsvAddr = 2'd2;
    #1;
    chk("r2_both_grant", oRsvGrant, 1);
    step();
    iWrEn = 1'b0; iRsvEn = 1'b0; iRdAddr0 = 2'd2;
    #1;
    chk("r2_both_data", oRdData0, 8'h22);
    chk("r2_both_busy", oBusy0, 1);
    chk("r2_both_cnt", oBusyCnt, 1);

    // 5. asynchronous reset with reservations pending
    iRsvEn = 1'b1; iRsvAddr = 2'd1;
    step();
    iRsvEn = 1'b0; iRdAddr1 = 2'd1;
    #1;
    chk("pend_cnt", oBusyCnt, 2);
    chk("pend_b1", oBusy1, 1);
    #2;
    iRst_n = 1'b0;
    #1;
    chk("arst_cnt", oBusyCnt, 0);
    chk("arst_b0", oBusy0, 0);
    chk("arst_b1", oBusy1, 0);
    chk("arst_d0", oRdData0, 0);
    #1;
    iRst_n = 1'b1;
    step();
    chk("post_cnt", oBusyCnt, 0);
    chk("post_b0", oBusy0, 0);
    iRsvEn = 1'b1; iRsvAddr = 2'd1;
    #1;
    chk("post_grant", oRsvGrant, 1);
    step();
    iRsvEn = 1'b0;
    #1;
    chk("post_cnt1", oBusyCnt, 1);

    // 6. same-cycle visibility of a write-back (r2 holds 0, r1 busy)
    iRdAddr0 = 2'd2; iRdAddr1 = 2'd1;
    iWrEn = 1'b1; iWrAddr = 2'd2; iWrData = 8'h5A;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_d0", oRdData0, 8'h5A);
`else
    chk("nobyp_d0", oRdData0, 8'h00);
`endif
    step();
    iWrAddr = 2'd1; iWrData = 8'h77;
    #1;
    chk("byp_next_d0", oRdData0, 8'h5A);
`ifdef REGFILE_BYPASS_EN
    chk("byp_b1", oBusy1, 0);
    chk("byp_d1", oRdData1, 8'h77);
`else
    chk("nobyp_b1", oBusy1, 1);
    chk("nobyp_d1", oRdData1, 8'h00);
`endif
    step();
    iWrEn = 1'b0;
    #1;
    chk("wb1_b1", oBusy1, 0);
    chk("wb1_d1", oRdData1, 8'h77);
    chk("wb1_cnt", oBusyCnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_regfile_scoreboard

`default_nettype wire
